// File: rtl/hash_fold_pkg.sv
// Shared constants, FSM state type and rotate helper for the hash digest folder.
package hash_fold_pkg;

  localparam int LANE_W     = 32;
  localparam int MAX_LANES  = 8;
  localparam int ROT_ABSORB = 5;
  localparam int ROT_MIX    = 11;

  localparam logic [LANE_W-1:0] IV [MAX_LANES] = '{
    32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    OUT    = 2'd3
  } fold_state_t;

  function automatic logic [LANE_W-1:0] rotl32(input logic [LANE_W-1:0] x,
                                               input int unsigned n);
    return (x << n) | (x >> (LANE_W - n));
  endfunction

endpackage

// File: rtl/hash_fold_lanes.sv
// Lane register file: absorbs words round-robin and applies the per-lane final mix.
module hash_fold_lanes
  import hash_fold_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int IDXW      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_reload,
  input  logic                        i_absorb,
  input  logic [LANE_W-1:0]           i_word,
  input  logic                        i_mix,
  input  logic [IDXW-1:0]             i_mix_idx,
  input  logic [LANE_W-1:0]           i_inject,
  output logic [LANE_W*NUM_LANES-1:0] o_lanes
);

  logic [LANE_W-1:0] r_lane [NUM_LANES];
  logic [IDXW-1:0]   r_idx;
  logic [IDXW-1:0]   w_mix_nxt;

  assign w_mix_nxt = (i_mix_idx == IDXW'(NUM_LANES-1)) ? '0 : i_mix_idx + 1'b1;

  // Mixing is done in place one lane per cycle, so the last lane sees lane 0 already mixed.
  always_ff @(posedge clk) begin
    if (!reset || i_reload) begin
      for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= IV[i];
      r_idx <= '0;
    end else if (i_absorb) begin
      r_lane[r_idx] <= rotl32(r_lane[r_idx], ROT_ABSORB) ^ i_word;
      r_idx         <= (r_idx == IDXW'(NUM_LANES-1)) ? '0 : r_idx + 1'b1;
    end else if (i_mix) begin
      r_lane[i_mix_idx] <= r_lane[i_mix_idx] ^ i_inject ^ rotl32(r_lane[w_mix_nxt], ROT_MIX);
    end
  end

  always_comb begin
    o_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) o_lanes[LANE_W*i +: LANE_W] = r_lane[i];
  end

endmodule

// File: rtl/hash_digest_fold.sv
// Folds a stream of hash words into NUM_LANES 32-bit lanes and emits a mixed digest.
// Optional build macro HASH_FOLD_LEN_EN injects the word count into lane 0 at finalisation.
module hash_digest_fold
  import hash_fold_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 hash_in,
  input  logic                        hash_valid,
  input  logic                        hash_last,
  output logic                        hash_ready,
  output logic [32*NUM_LANES-1:0]     digest_out,
  output logic [15:0]                 digest_words,
  output logic                        digest_valid,
  input  logic                        digest_ready
);

  localparam int IDXW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  fold_state_t       r_state;
  logic [15:0]       r_cnt;
  logic [IDXW-1:0]   r_k;
  logic              r_hash_ready;
  logic              r_digest_valid;

  logic              w_accept;
  logic              w_mix;
  logic              w_reload;
  logic [31:0]       w_inject;
  logic [32*NUM_LANES-1:0] w_lanes;

  assign w_accept = hash_valid && r_hash_ready;
  assign w_mix    = (r_state == FINAL);
  assign w_reload = (r_state == OUT) && digest_ready;

`ifdef HASH_FOLD_LEN_EN
  assign w_inject = (w_mix && r_k == '0) ? {16'h0, r_cnt} : 32'h0;
`else
  assign w_inject = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_k            <= '0;
      r_hash_ready   <= 1'b1;
      r_digest_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ABSORB: begin
          if (w_accept) begin
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            if (hash_last) begin
              r_state      <= FINAL;
              r_hash_ready <= 1'b0;
              r_k          <= '0;
            end else begin
              r_state <= ABSORB;
            end
          end
        end
        FINAL: begin
          if (r_k == IDXW'(NUM_LANES-1)) begin
            r_state        <= OUT;
            r_digest_valid <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        OUT: begin
          if (digest_ready) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_digest_valid <= 1'b0;
            r_hash_ready   <= 1'b1;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_hash_ready   <= 1'b1;
          r_digest_valid <= 1'b0;
        end
      endcase
    end
  end

  hash_fold_lanes #(.NUM_LANES(NUM_LANES), .IDXW(IDXW)) u_lanes (
    .clk       (clk),
    .reset     (reset),
    .i_reload  (w_reload),
    .i_absorb  (w_accept),
    .i_word    (hash_in),
    .i_mix     (w_mix),
    .i_mix_idx (r_k),
    .i_inject  (w_inject),
    .o_lanes   (w_lanes)
  );

  assign hash_ready   = r_hash_ready;
  assign digest_valid = r_digest_valid;
  assign digest_out   = w_lanes;
  assign digest_words = r_cnt;

endmodule

// File: doc/hash_digest_fold.md
HASH_DIGEST_FOLD -- requirements
Module: hash_digest_fold

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, meaning the number of 32-bit digest lanes; legal range is 2..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port hash_in, input, 32, the hash word from the upstream LFSR/Toeplitz hash stage.
REQ-005 SHALL have port hash_valid, input, 1, meaning hash_in is valid this cycle.
REQ-006 SHALL have port hash_last, input, 1, meaning hash_in is the final word of the message; it is qualified by hash_valid.
REQ-007 SHALL have port hash_ready, output, 1, meaning the block accepts hash_in this cycle.
REQ-008 SHALL have port digest_out, output, 32*NUM_LANES, the folded digest with lane 0 in the LSBs.
REQ-009 SHALL have port digest_words, output, 16, the number of words in the digested message.
REQ-010 SHALL have port digest_valid, output, 1, meaning the digest is available.
REQ-011 SHALL have port digest_ready, input, 1, meaning the consumer accepts the digest.

Function
REQ-012 SHALL implement an FSM with states IDLE, ABSORB, FINAL and OUT.
REQ-013 SHALL assert hash_ready only in IDLE or ABSORB; a word is accepted on any edge where hash_valid and hash_ready are both 1.
REQ-014 SHALL, on acceptance, update lane[idx] <= rotl32(lane[idx],5) ^ hash_in, then advance idx with wrap from NUM_LANES-1 to 0.
REQ-015 SHALL move IDLE->ABSORB on a non-last acceptance, and IDLE or ABSORB->FINAL on a last acceptance.
REQ-016 SHALL increment a 16-bit word counter per acceptance, saturating at 0xFFFF.
REQ-017 SHALL, in FINAL, mix one lane per cycle for k = 0..NUM_LANES-1: lane[k] <= lane[k] ^ rotl32(lane[(k+1) mod NUM_LANES],11).
REQ-018 SHALL use current register values when mixing lane NUM_LANES-1, so lane 0 is already mixed at that point.
REQ-019 SHALL enter OUT after the last mix step, so digest_valid first reads 1 after the NUM_LANES-th rising edge following last-word acceptance.
REQ-020 SHALL hold digest_out, digest_words and digest_valid stable in OUT until digest_ready=1.
REQ-021 SHALL, on the digest handshake edge, reload the lanes with IV, clear idx and the counter, and enter IDLE; hash_ready is 1 in the next cycle.
REQ-022 SHALL ignore hash_valid and hash_last while in FINAL or OUT; no word is consumed.
REQ-023 SHALL treat a single-word message (last on the first word) as legal, giving digest_words=1.
REQ-024 SHALL drive digest_out with the live lane registers, digest_words with the counter, and digest_valid=1 only in OUT.

Reset
REQ-025 SHALL, when reset=0 at a rising edge, enter IDLE, load lane[i]=IV[i], clear idx and the counter, and drive digest_valid=0.
REQ-026 SHALL hold hash_ready=1 after reset release.
REQ-027 SHALL abort a partial message or pending digest on reset mid-operation, with no digest emitted.

Configuration
REQ-028 SHALL, with HASH_FOLD_LEN_EN defined, additionally XOR {16'h0, counter} into lane 0 on the first FINAL cycle, before lane 0 mixing in the same update.
REQ-029 SHALL, without HASH_FOLD_LEN_EN, exclude length injection, with FINAL timing unchanged.

Structure
REQ-030 SHALL place the following in package hash_fold_pkg: the IV table (8 words: 6A09E667, BB67AE85, 3C6EF372, A54FF53A, 510E527F, 9B05688C, 1F83D9AB, 5BE0CD19), the state enum, the rotate amounts 5 and 11, and the rotl32 function.
REQ-031 SHALL place the lane register array with its absorb and mix update logic in one sub-module, hash_fold_lanes; the FSM and counter stay in hash_digest_fold.

Verification
REQ-032 SHALL cover: after reset, NUM_LANES=4 -> hash_ready=1, digest_valid=0, digest_out={IV3,IV2,IV1,IV0}.
REQ-033 SHALL cover: 3 words 0x00000001, 0x00000002, 0x00000003 (last on third) -> digest_valid high exactly 4 edges after the third acceptance, digest_words=3, and digest_out matching the bench model.
REQ-034 SHALL cover: digest_ready held 0 for 10 cycles in OUT, with hash_valid=1 -> digest_out stable, hash_ready=0, no word consumed.
REQ-035 SHALL cover: 5 words with NUM_LANES=4 -> lane 0 absorbs words 1 and 5 (idx wrap), matching the model.
REQ-036 SHALL cover: a single word 0xDEADBEEF with last, once with and once without HASH_FOLD_LEN_EN -> digests differ only as predicted by the model, digest_words=1.
REQ-037 SHALL cover: reset=0 asserted after 2 words of a message -> IDLE, IV lanes, no digest_valid pulse, and the next message is digested correctly.
